// File: rtl/ins_mem_pkg.sv
// rtl/ins_mem_pkg.sv - shared types and constants for the instruction-memory responder
package ins_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

    // Counter is loaded with LATENCY-1, so anything below one cannot be expressed.
    localparam int MIN_LATENCY = 1;

endpackage

// File: rtl/ins_mem_responder_if.sv
// rtl/ins_mem_responder_if.sv - fetch request/response bundle between cpu and instruction memory
interface ins_mem_responder_if #(
    parameter int DWIDTH = 16
) ();

    logic              en_ram_in;
    logic [DWIDTH-1:0] addr;
    logic [DWIDTH-1:0] ins;
    logic              en_ram_out;
    logic              addr_err;
    logic              busy;
    logic              drop;

    modport master (
        output en_ram_in,
        output addr,
        input  ins,
        input  en_ram_out,
        input  addr_err,
        input  busy,
        input  drop
    );

    modport slave (
        input  en_ram_in,
        input  addr,
        output ins,
        output en_ram_out,
        output addr_err,
        output busy,
        output drop
    );

endinterface

// File: rtl/ins_mem_array.sv
// rtl/ins_mem_array.sv - DEPTH x DWIDTH program store, sync write port, sync read-before-write port
module ins_mem_array #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DWIDTH-1:0]        rd_data
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rd_data_q;
    logic [DWIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Only the read register is reset; a same-edge write lands after this sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ins_mem_responder.sv
// rtl/ins_mem_responder.sv - fixed-latency fetch responder FSM over ins_mem_array
// Optional REQ_BUF_EN adds a one-entry buffer for requests arriving while a fetch is in flight.
module ins_mem_responder
    import ins_mem_pkg::*;
#(
    parameter int                DWIDTH   = 16,
    parameter int                DEPTH    = 256,
    parameter int                LATENCY  = 2,
    parameter logic [DWIDTH-1:0] NOP_WORD = DWIDTH'(NOP_WORD_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    ins_mem_responder_if.slave       fetch,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DWIDTH-1:0]        load_data
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]   CNT_START = CW'(LATENCY - 1);
    localparam logic [DWIDTH:0] DEPTH_W   = (DWIDTH + 1)'(DEPTH);

    if (LATENCY < MIN_LATENCY) begin : g_latency_check
        $error("ins_mem_responder: LATENCY must be at least %0d", MIN_LATENCY);
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic              en_ram_out_q, en_ram_out_d;
    logic              addr_err_q, addr_err_d;
    logic              drop_q, drop_d;
    logic              nop_sel_q, nop_sel_d;

    logic              resp_fire;
    logic              in_range;
    logic [DWIDTH-1:0] rd_data;

    // Full-width compare so out-of-range addresses never alias into the array.
    assign in_range  = ({1'b0, addr_q} < DEPTH_W);
    assign resp_fire = (state_q == WAIT) && (cnt_q == '0);

`ifdef REQ_BUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [DWIDTH-1:0] buf_addr_q, buf_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            en_ram_out_q <= 1'b0;
            addr_err_q   <= 1'b0;
            drop_q       <= 1'b0;
            nop_sel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            en_ram_out_q <= en_ram_out_d;
            addr_err_q   <= addr_err_d;
            drop_q       <= drop_d;
            nop_sel_q    <= nop_sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        en_ram_out_d = 1'b0;
        addr_err_d   = 1'b0;
        drop_d       = 1'b0;
        nop_sel_d    = nop_sel_q;
`ifdef REQ_BUF_EN
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
`endif

        case (state_q)
            IDLE: begin
                if (fetch.en_ram_in) begin
                    addr_d  = fetch.addr;
                    cnt_d   = CNT_START;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    en_ram_out_d = 1'b1;
                    addr_err_d   = !in_range;
                    nop_sel_d    = !in_range;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`ifdef REQ_BUF_EN
                if (fetch.en_ram_in) begin
                    if (buf_valid_q) begin
                        drop_d = 1'b1;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = fetch.addr;
                    end
                end
`else
                drop_d = fetch.en_ram_in;
`endif
            end

            RESP: begin
`ifdef REQ_BUF_EN
                if (buf_valid_q) begin
                    // Buffered request goes first; a fresh request refills the buffer.
                    addr_d      = buf_addr_q;
                    cnt_d       = CNT_START;
                    state_d     = WAIT;
                    buf_valid_d = fetch.en_ram_in;
                    if (fetch.en_ram_in) begin
                        buf_addr_d = fetch.addr;
                    end
                end else if (fetch.en_ram_in) begin
`else
                if (fetch.en_ram_in) begin
`endif
                    addr_d  = fetch.addr;
                    cnt_d   = CNT_START;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ins_mem_array #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (load_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (resp_fire && in_range),
        .rd_addr (addr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign fetch.ins        = nop_sel_q ? NOP_WORD : rd_data;
    assign fetch.en_ram_out = en_ram_out_q;
    assign fetch.addr_err   = addr_err_q;
    assign fetch.drop       = drop_q;
`ifdef REQ_BUF_EN
    assign fetch.busy       = buf_valid_q;
`else
    assign fetch.busy       = (state_q == WAIT);
`endif

endmodule

// File: doc/ins_mem_responder.md
Name: ins_mem_responder

Overview:
Instruction-memory responder for the cpu's fetch interface. Accepts a fetch request (en_ram_in + addr) and returns the instruction word on ins with a one-cycle en_ram_out strobe after a fixed, parameterised latency. Holds the program in an internal array that a separate load port fills before or during run.

Parameters:
DWIDTH, 16, instruction word width and fetch address width
DEPTH, 256, number of instruction words; addresses 0..DEPTH-1 are valid
LATENCY, 2, clock edges from request sample to response strobe; must be >= 1
NOP_WORD, 16'h0000, word returned for out-of-range addresses

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en_ram_in  input  1  fetch request strobe from cpu
addr  input  DWIDTH  fetch address, sampled with en_ram_in
ins  output  DWIDTH  returned instruction word, registered
en_ram_out  output  1  response strobe, one cycle per accepted request
addr_err  output  1  high with en_ram_out when the served address was >= DEPTH
busy  output  1  high when a new request would not be accepted
drop  output  1  one-cycle pulse when a request is discarded
load_we  input  1  program-load write enable
load_addr  input  $clog2(DEPTH)  program-load address
load_data  input  DWIDTH  program-load data

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: ins=0, en_ram_out=0, addr_err=0, busy=0, drop=0, state IDLE, counter 0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: en_ram_in=1 at edge k -> latch addr, cnt=LATENCY-1, go to WAIT.
- WAIT: busy=1. If cnt==0, register the array word into ins, pulse en_ram_out, and go to RESP; otherwise decrement cnt.
- Response timing: en_ram_out is high for exactly the cycle after edge k+LATENCY. For LATENCY=1 it is the cycle right after the next edge.
- RESP: busy=0. en_ram_in here is accepted exactly as in IDLE (back-to-back fetch), going to WAIT. Otherwise go to IDLE.
- Sustained fetches: throughput is one request per LATENCY+1 cycles.
- ins holds its last value after the strobe. It changes only on a response.
- Out of range: latched addr >= DEPTH -> ins=NOP_WORD and addr_err=1, same cycle as en_ram_out. The upper address bits are never truncated to alias into the array.
- Request during WAIT (feature off): request is discarded and drop pulses the next cycle. The in-flight request is unaffected.
- load_we: synchronous write, accepted in any state. When the write and the response read hit the same address on the same edge, the response returns the old word (read-before-write).
- Reset mid-operation: pending and buffered requests are discarded, no en_ram_out is produced, and the FSM returns to IDLE.

Optional Feature:
REQ_BUF_EN
- Defined: a one-entry request buffer captures addr when en_ram_in arrives during WAIT. After that response, RESP goes directly to WAIT for the buffered address, with the same LATENCY. busy=1 only while the buffer is full. A request arriving while the buffer is full is discarded and drop pulses.
- Undefined: no buffer. busy=1 throughout WAIT, and every request arriving in WAIT is dropped.

Decomposition:
- Package ins_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - default NOP_WORD constant
  - LATENCY lower-bound check constant
- Sub-module ins_mem_array holds DEPTH x DWIDTH storage: synchronous write port (load_*) and synchronous read port with read-before-write. The FSM, counter, buffer and out-of-range logic stay in the top level.

Test Plan:
- Reset then load: load 0x10=16'hA5C3, LATENCY=2, request addr=0x10 at edge k -> en_ram_out high for exactly the one cycle after edge k+2; ins=16'hA5C3; addr_err=0.
- Back-to-back: request 0x01 then 0x02 issued in its RESP cycle (words 16'h1111, 16'h2222) -> two strobes 3 cycles apart, returning 16'h1111 then 16'h2222.
- Out of range: request addr=16'h0100 with DEPTH=256 -> ins=16'h0000, addr_err=1 with the strobe.
- Busy collision, REQ_BUF_EN off: second request during WAIT -> drop pulse, exactly one en_ram_out. With REQ_BUF_EN: two en_ram_out strobes in order, and a third request while the buffer is full -> drop.
- Read/write collision: load_we to 0x05 (old 16'h0F0F, new 16'hF0F0) on the response edge -> ins=16'h0F0F; the next fetch of 0x05 returns 16'hF0F0.
- Reset mid-WAIT: assert rst one cycle after the request -> no en_ram_out, and all outputs go to 0 asynchronously.
